mem_stage_lsu: RTL and testbench

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/pipeline_flow_types.sv | 26 ++
 rtl/lsu_align.sv | 24 ++
 rtl/mem_stage_lsu.sv | 93 +++++++++
 tb/tb_mem_stage_lsu.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_flow_types.sv
// pipeline_flow_types: EX/MEM and MEM/WB flow records shared by the memory stage.
package pipeline_flow_types;
  localparam int FLOW_XLEN = 32;
  typedef enum logic [1:0] {BYTE, HALF, WORD} mem_size_e;
  typedef enum logic [1:0] {IDLE, BUS, DONE} lsu_state_e;
  typedef struct packed {
    logic                 valid;
    logic                 mem_read;
    logic                 mem_write;
    mem_size_e            mem_size;
    logic                 mem_unsigned;
    logic [FLOW_XLEN-1:0] alu_result;
    logic [FLOW_XLEN-1:0] rs2_data;
    logic [4:0]           rd;
    logic                 reg_write;
  } ex_mem_flow_t;
  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic [4:0]           rd;
    logic [FLOW_XLEN-1:0] wb_data;
    logic                 exc_misalign;
    logic                 exc_bus;
  } mem_wb_flow_t;
  localparam mem_wb_flow_t NOP_MEM_WB_FLOW = '0;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane placement, byte enables, load lane select/extension and misalign detection.
module lsu_align
  import pipeline_flow_types::*;
(
  input  logic [1:0]           addr_lo,
  input  mem_size_e            size,
  input  logic                 is_unsigned,
  input  logic [FLOW_XLEN-1:0] store_data,
  input  logic [FLOW_XLEN-1:0] load_word,
  output logic [FLOW_XLEN-1:0] wdata,
  output logic [3:0]           be,
  output logic [FLOW_XLEN-1:0] load_data,
  output logic                 misaligned
);
  logic [15:0] lane;
  always_comb begin
    lane       = 16'(load_word >> {addr_lo, 3'b000});
    misaligned = (size == HALF && addr_lo[0]) || (size == WORD && addr_lo != 2'b00);
    be         = size == BYTE ? 4'b0001 << addr_lo : size == HALF ? 4'b0011 << addr_lo : 4'b1111;
    wdata      = size == BYTE ? {4{store_data[7:0]}} : size == HALF ? {2{store_data[15:0]}} : store_data;
    load_data  = size == BYTE ? {{24{~is_unsigned & lane[7]}}, lane[7:0]} :
                 size == HALF ? {{16{~is_unsigned & lane[15]}}, lane[15:0]} : load_word;
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit, one blocking data-bus transaction per access.
module mem_stage_lsu
  import pipeline_flow_types::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int XLEN           = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  ex_mem_flow_t      mem_flow,
  input  logic              flush,
  output mem_wb_flow_t      wb_flow,
  output logic              stall_req,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [XLEN-1:0]   dbus_addr,
  output logic [XLEN-1:0]   dbus_wdata,
  output logic [XLEN/8-1:0] dbus_be,
  input  logic [XLEN-1:0]   dbus_rdata,
  input  logic              dbus_ack
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  lsu_state_e state, state_n;
  ex_mem_flow_t req, cur;
  logic [XLEN-1:0] rdata_q, wdata, load_data;
  logic [XLEN/8-1:0] be;
  logic [CW-1:0] cnt;
  logic killed, bus_err, misaligned, is_mem, launch, timeout;
  // Alignment logic sees the live instruction while idle, the latched one once the bus is owned.
  assign cur = state == IDLE ? mem_flow : req;
  lsu_align u_align (
    .addr_lo     (cur.alu_result[1:0]),
    .size        (cur.mem_size),
    .is_unsigned (cur.mem_unsigned),
    .store_data  (cur.rs2_data),
    .load_word   (rdata_q),
    .wdata       (wdata),
    .be          (be),
    .load_data   (load_data),
    .misaligned  (misaligned)
  );
  always_comb begin
    is_mem     = mem_flow.valid && (mem_flow.mem_read || mem_flow.mem_write);
    launch     = state == IDLE && is_mem && !misaligned && !flush;
    timeout    = state == BUS && !dbus_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
    state_n    = state == IDLE ? (launch ? BUS : IDLE) :
                 state == BUS  ? (dbus_ack || timeout ? DONE : BUS) : IDLE;
    dbus_req   = state == BUS && !reset;
    dbus_we    = dbus_req && req.mem_write;
    dbus_addr  = dbus_req ? {req.alu_result[XLEN-1:2], 2'b00} : '0;
    dbus_be    = dbus_req ? be : '0;
    dbus_wdata = dbus_req ? wdata : '0;
    stall_req  = !reset && (launch || state == BUS);
    wb_flow    = NOP_MEM_WB_FLOW;
    if (!reset && !flush && state == IDLE && mem_flow.valid && !(is_mem && !misaligned)) begin
      wb_flow.valid        = 1'b1;
      wb_flow.rd           = mem_flow.rd;
      wb_flow.wb_data      = mem_flow.alu_result;
      wb_flow.exc_misalign = is_mem;
      wb_flow.reg_write    = mem_flow.reg_write && !is_mem;
    end else if (!reset && !flush && state == DONE && !killed) begin
      wb_flow.valid     = 1'b1;
      wb_flow.rd        = req.rd;
      wb_flow.wb_data   = req.mem_read ? load_data : req.alu_result;
      wb_flow.exc_bus   = bus_err;
      wb_flow.reg_write = req.mem_read && req.reg_write && !bus_err;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      req     <= '0;
      rdata_q <= '0;
      cnt     <= '0;
      killed  <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_n;
      if (launch) begin
        req     <= mem_flow;
        cnt     <= '0;
        killed  <= 1'b0;
        bus_err <= 1'b0;
      end
      if (state == BUS) begin
        cnt <= CW'(cnt + 1'b1);
        if (flush) killed <= 1'b1;
        if (dbus_ack) rdata_q <= dbus_rdata;
        if (timeout) bus_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and randomized checks of mem_stage_lsu against a per-instruction reference model.
module tb_mem_stage_lsu;
  import pipeline_flow_types::*;
  logic clk = 1'b0;
  logic reset, flush, stall_req, dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0] dbus_be;
  ex_mem_flow_t mem_flow;
  mem_wb_flow_t wb_flow;
  int errs = 0, checks = 0;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .mem_flow(mem_flow), .flush(flush), .wb_flow(wb_flow),
    .stall_req(stall_req), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ex_mem_flow_t mk(bit v, bit r, bit w, mem_size_e sz, bit u,
                                      logic [31:0] a, logic [31:0] d, logic [4:0] rdx, bit rw);
    ex_mem_flow_t f;
    f.valid = v; f.mem_read = r; f.mem_write = w; f.mem_size = sz; f.mem_unsigned = u;
    f.alu_result = a; f.rs2_data = d; f.rd = rdx; f.reg_write = rw;
    return f;
  endfunction

  function automatic int nbytes(mem_size_e sz);
    return sz == BYTE ? 1 : sz == HALF ? 2 : 4;
  endfunction

  function automatic logic [31:0] ld_model(mem_size_e sz, bit uns, int a, logic [31:0] w);
    int unsigned v, span;
    if (sz == WORD) return w;
    span = sz == BYTE ? 256 : 65536;
    v = (w >> (8 * a)) % span;
    if (!uns && v >= span / 2) v = v - span;
    return v;
  endfunction

  function automatic logic [31:0] st_model(mem_size_e sz, logic [31:0] d);
    return sz == BYTE ? (d % 256) * 32'h01010101 : sz == HALF ? (d % 65536) * 32'h00010001 : d;
  endfunction

  // Drive one instruction from an idle MEM stage through to its write-back; called at a falling edge.
  task automatic run(input ex_mem_flow_t f, input int ack_at, input bit fl_idle, input int fl_bus,
                     input logic [31:0] rdata);
    int a, nb;
    bit mis, is_mem, killed, got_ack;
    nb = nbytes(f.mem_size);
    a = f.alu_result % 4;
    mis = (f.alu_result % nb) != 0;
    is_mem = f.valid && (f.mem_read || f.mem_write);
    killed = 0;
    got_ack = 0;
    mem_flow = f;
    flush = fl_idle;
    dbus_ack = ($urandom % 4) == 0;
    dbus_rdata = $urandom;
    #1;
    check("idle_req", dbus_req, 0);
    if (!f.valid || fl_idle) begin
      check("idle_nop", wb_flow, NOP_MEM_WB_FLOW);
      check("idle_stall", stall_req, 0);
    end else if (is_mem && mis) begin
      check("mis_flags", {wb_flow.valid, wb_flow.reg_write, wb_flow.exc_misalign, wb_flow.exc_bus}, 4'b1010);
      check("mis_stall", stall_req, 0);
    end else if (!is_mem) begin
      check("pass_data", wb_flow.wb_data, f.alu_result);
      check("pass_flags", {wb_flow.valid, wb_flow.reg_write, wb_flow.rd, wb_flow.exc_misalign, wb_flow.exc_bus},
            {1'b1, f.reg_write, f.rd, 2'b00});
      check("pass_stall", stall_req, 0);
    end else begin
      check("launch_stall", stall_req, 1);
      check("launch_wb_valid", wb_flow.valid, 0);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        dbus_ack = 0;
        flush = (k == fl_bus);
        #1;
        check("bus_req", dbus_req, 1);
        check("bus_stall", stall_req, 1);
        check("bus_addr", dbus_addr, f.alu_result - a);
        check("bus_we", dbus_we, f.mem_write);
        check("bus_be", dbus_be, ((1 << nb) - 1) << a);
        if (f.mem_write) check("bus_wdata", dbus_wdata, st_model(f.mem_size, f.rs2_data));
        if (k == fl_bus) killed = 1;
        if (k == ack_at) begin
          dbus_ack = 1;
          dbus_rdata = rdata;
          got_ack = 1;
          break;
        end
      end
      @(negedge clk);
      dbus_ack = 0;
      flush = 0;
      #1;
      check("done_stall", stall_req, 0);
      check("done_req", dbus_req, 0);
      if (killed) check("done_nop", wb_flow, NOP_MEM_WB_FLOW);
      else begin
        check("done_flags", {wb_flow.valid, wb_flow.reg_write, wb_flow.rd, wb_flow.exc_misalign, wb_flow.exc_bus},
              {1'b1, f.mem_read && f.reg_write && got_ack, f.rd, 1'b0, !got_ack});
        if (f.mem_read && got_ack) check("load_data", wb_flow.wb_data, ld_model(f.mem_size, f.mem_unsigned, a, rdata));
      end
    end
    @(negedge clk);
    flush = 0;
    dbus_ack = 0;
  endtask

  initial begin
    reset = 1;
    flush = 0;
    dbus_ack = 0;
    dbus_rdata = '0;
    mem_flow = mk(1, 0, 0, WORD, 0, 32'h1234, 0, 5, 1);
    repeat (2) @(negedge clk);
    #1;
    check("rst_wb", wb_flow, NOP_MEM_WB_FLOW);
    check("rst_stall", stall_req, 0);
    check("rst_req", dbus_req, 0);
    check("rst_be", dbus_be, 0);
    @(negedge clk);
    reset = 0;
    run(mk(1, 1, 0, WORD, 0, 32'h100, 0, 3, 1), 0, 0, -1, 32'hDEADBEEF);
    run(mk(1, 1, 0, BYTE, 0, 32'h103, 0, 4, 1), 0, 0, -1, 32'h80112233);
    run(mk(1, 1, 0, BYTE, 1, 32'h103, 0, 4, 1), 1, 0, -1, 32'h80112233);
    run(mk(1, 0, 1, HALF, 0, 32'h102, 32'h0000ABCD, 0, 0), 0, 0, -1, 0);
    run(mk(1, 1, 0, WORD, 0, 32'h101, 0, 6, 1), 0, 0, -1, 0);
    run(mk(1, 1, 0, WORD, 0, 32'h200, 0, 7, 1), -1, 0, -1, 0);
    run(mk(1, 1, 0, HALF, 0, 32'h202, 0, 8, 1), 2, 0, 1, 32'h8001FFFF);
    run(mk(1, 0, 1, WORD, 0, 32'h300, 32'h55AA55AA, 0, 0), 0, 1, -1, 0);
    mem_flow = mk(1, 1, 0, WORD, 0, 32'h400, 0, 9, 1);
    @(negedge clk);
    #1;
    check("rb_req", dbus_req, 1);
    reset = 1;
    @(negedge clk);
    #1;
    check("rb_req_after", dbus_req, 0);
    check("rb_stall", stall_req, 0);
    check("rb_wb", wb_flow, NOP_MEM_WB_FLOW);
    mem_flow = '0;
    reset = 0;
    @(negedge clk);
    #1;
    check("rb_idle_req", dbus_req, 0);
    @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      int kind;
      mem_size_e sz;
      logic [31:0] addr;
      kind = $urandom % 3;
      sz = mem_size_e'($urandom % 3);
      addr = $urandom;
      if ($urandom % 3 != 0) addr = addr & ~32'(nbytes(sz) - 1);
      run(mk(($urandom % 8) != 0, kind == 1, kind == 2, sz, $urandom % 2, addr, $urandom,
             5'($urandom), kind != 2),
          $urandom % 6, ($urandom % 10) == 0, ($urandom % 5 == 0) ? int'($urandom % 4) : -1, $urandom);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
